// File: rtl/pulse_gen_v1.sv
// pulse_gen_v1: synthetic detector-pulse source.
// Each accepted trigger produces a step rise followed by an exponential tail
// with time constant 2^DECAY_SHIFT samples, one sample per clock. A dead time
// of HOLDOFF cycles follows each pulse. Optional pile-up adds a new step onto
// a decaying tail. The accumulator is 16-bit unsigned 8.8 fixed point.
module pulse_gen_v1 #(
    parameter int DECAY_SHIFT = 4,
    parameter int BASELINE    = 0,
    parameter int HOLDOFF     = 8,
    parameter int PILEUP_EN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] AMP,
    output logic [7:0] OUT,
    output logic       busy,
    output logic       done,
    output logic [7:0] dropped
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DECAY = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] BASE8 = 8'(BASELINE);
    localparam logic [7:0] HOLD8 = 8'(HOLDOFF);

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  drop_q, drop_d;
    logic [7:0]  out_q, out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        trig;
    logic [15:0] amp_fx;
    logic [15:0] tail;

    // 16-bit add clamped at 0xFFFF (pile-up onto a large tail)
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Baseline plus integer part of the accumulator, clamped to 8 bits via a 9-bit sum
    function automatic logic [7:0] sat_out(input logic [7:0] hi);
        logic [8:0] s;
        s = {1'b0, BASE8} + {1'b0, hi};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Refused-trigger counter sticks at 255
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign trig   = start && (AMP != 8'd0);
    assign amp_fx = {AMP, 8'h00};
    assign tail   = acc_q - (acc_q >> DECAY_SHIFT);

    // Next-state, accumulator, counters and registered-output values
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                acc_d = 16'd0;
                if (trig) begin
                    acc_d   = amp_fx;
                    state_d = S_DECAY;
                end
            end
            S_DECAY: begin
                if (trig && (PILEUP_EN != 0)) begin
                    // A pile-up add keeps the pulse alive even if the tail would end now
                    acc_d = sat_add16(tail, amp_fx);
                end else begin
                    acc_d = tail;
                    if (trig) begin
                        drop_d = sat_inc(drop_q);
                    end
                    if (tail[15:8] == 8'd0) begin
                        acc_d  = 16'd0;
                        done_d = 1'b1;
                        if (HOLDOFF > 0) begin
                            state_d = S_HOLD;
                            cnt_d   = HOLD8;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_HOLD: begin
                acc_d = 16'd0;
                cnt_d = cnt_q - 8'd1;
                if (trig) begin
                    drop_d = sat_inc(drop_q);
                end
                if (cnt_q <= 8'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = 16'd0;
                cnt_d   = 8'd0;
            end
        endcase
        out_d  = sat_out(acc_d[15:8]);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any pulse immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= 16'd0;
            cnt_q   <= 8'd0;
            drop_q  <= 8'd0;
            out_q   <= BASE8;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign OUT     = out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign dropped = drop_q;

endmodule
